arf_sequencer: RTL and testbench

- Micro-sequencer for the 8-bit address register file (AR, SP, PC_past, PC).
- Accepts one pointer command at a time over a valid/ready handshake.
- Expands each command into 1-2 cycles of register-file controls: funsel, r_sel, out_a_sel, out_b_sel and the shared load bus. Memory address/strobe outputs are driven in the same cycles.
- Sits between the control unit and the register file; it is the only driver of the register file's control inputs.

---
 rtl/arf_pkg.sv | 46 ++++
 rtl/arf_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_arf_sequencer.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/arf_pkg.sv
// ---------------------------------------------------------------------------
// arf_pkg
// Shared encodings for the address-register-file sequencer:
//   - register-file function codes (funsel)
//   - register select codes for the A/B read ports
//   - one-hot r_sel write-enable masks, bit order {AR, SP, PC_past, PC}
//   - command opcodes accepted on the sequencer's command port
//   - sequencer state enum
// ---------------------------------------------------------------------------
package arf_pkg;

    // Register-file function applied to every register whose r_sel bit is set
    localparam logic [1:0] FS_CLR  = 2'b00;
    localparam logic [1:0] FS_LOAD = 2'b01;
    localparam logic [1:0] FS_DEC  = 2'b10;
    localparam logic [1:0] FS_INC  = 2'b11;

    // Read-port select codes
    localparam logic [1:0] SEL_AR  = 2'b00;
    localparam logic [1:0] SEL_SP  = 2'b01;
    localparam logic [1:0] SEL_PCP = 2'b10;
    localparam logic [1:0] SEL_PC  = 2'b11;

    // r_sel write-enable masks
    localparam logic [3:0] RS_NONE = 4'b0000;
    localparam logic [3:0] RS_AR   = 4'b1000;
    localparam logic [3:0] RS_SP   = 4'b0100;
    localparam logic [3:0] RS_PCP  = 4'b0010;
    localparam logic [3:0] RS_PC   = 4'b0001;
    localparam logic [3:0] RS_ALL  = 4'b1111;

    // Command opcodes; 6 and 7 are illegal and get rejected
    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_FETCH = 3'd1;
    localparam logic [2:0] OP_PUSH  = 3'd2;
    localparam logic [2:0] OP_POP   = 3'd3;
    localparam logic [2:0] OP_JUMP  = 3'd4;
    localparam logic [2:0] OP_INIT  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC1 = 2'd1,
        ST_EXEC2 = 2'd2
    } state_t;

endpackage

// File: rtl/arf_sequencer.sv
// ---------------------------------------------------------------------------
// arf_sequencer
// Micro-sequencer for the 8-bit address register file (AR, SP, PC_past, PC).
// Takes one pointer command at a time over valid/ready and expands it into
// one or two cycles of register-file controls plus memory strobes.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   cmd_valid  command present
//   cmd_ready  sequencer idle and able to accept
//   cmd_op     opcode (0 NOP,1 FETCH,2 PUSH,3 POP,4 JUMP,5 INIT,6-7 illegal)
//   cmd_data   jump target (JUMP only)
//   arf_a      register-file A-port read data, fed back
//   funsel     register-file function
//   r_sel      register write enables {AR, SP, PC_past, PC}
//   out_a_sel  register-file A-port select
//   out_b_sel  register-file B-port select (always AR)
//   arf_i      register-file load bus
//   mem_addr   memory address (arf_a while a strobe is high, else 0)
//   mem_rd     memory read strobe
//   mem_wr     memory write strobe
//   done       pulse in the last cycle of an executed command
//   err        pulse when a command is rejected
// ---------------------------------------------------------------------------
module arf_sequencer
    import arf_pkg::*;
#(
    parameter logic [7:0] SP_INIT  = 8'hFF,
    parameter logic [7:0] SP_LIMIT = 8'h80
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [7:0] cmd_data,
    input  logic [7:0] arf_a,
    output logic [1:0] funsel,
    output logic [3:0] r_sel,
    output logic [1:0] out_a_sel,
    output logic [1:0] out_b_sel,
    output logic [7:0] arf_i,
    output logic [7:0] mem_addr,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       done,
    output logic       err
);

    state_t     r_state;
    logic [2:0] r_op;
    logic [7:0] r_data;

    logic       w_accept;
    logic       w_two_cycle;   // EXEC1 continues into EXEC2
    logic       w_sp_full;
    logic       w_sp_empty;

    assign cmd_ready = (r_state == ST_IDLE);
    assign w_accept  = cmd_valid & cmd_ready;

    // Only meaningful in EXEC1 of PUSH/POP, where the A port is steered to SP
    assign w_sp_full  = (arf_a == SP_LIMIT);
    assign w_sp_empty = (arf_a == SP_INIT);

    // -----------------------------------------------------------------------
    // State and captured command
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_op    <= OP_NOP;
            r_data  <= 8'h00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= ST_EXEC1;
                        r_op    <= cmd_op;
                        r_data  <= cmd_data;
                    end
                end
                ST_EXEC1: r_state <= w_two_cycle ? ST_EXEC2 : ST_IDLE;
                ST_EXEC2: r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Control decode from state + captured command. Everything defaults to
    // zero, so IDLE holds every register and drives no strobes.
    // -----------------------------------------------------------------------
    always_comb begin
        funsel      = FS_CLR;
        r_sel       = RS_NONE;
        out_a_sel   = SEL_AR;
        out_b_sel   = SEL_AR;
        arf_i       = 8'h00;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        w_two_cycle = 1'b0;

        case (r_state)
            ST_EXEC1: begin
                case (r_op)
                    OP_NOP: done = 1'b1;
                    OP_FETCH: begin
                        // Copy PC into PC_past while PC addresses memory
                        out_a_sel   = SEL_PC;
                        mem_rd      = 1'b1;
                        funsel      = FS_LOAD;
                        r_sel       = RS_PCP;
                        arf_i       = arf_a;
                        w_two_cycle = 1'b1;
                    end
                    OP_PUSH: begin
                        out_a_sel = SEL_SP;
                        if (w_sp_full) begin
                            err = 1'b1;
                        end else begin
                            mem_wr      = 1'b1;
                            w_two_cycle = 1'b1;
                        end
                    end
                    OP_POP: begin
                        out_a_sel = SEL_SP;
                        if (w_sp_empty) begin
                            err = 1'b1;
                        end else begin
                            funsel      = FS_INC;
                            r_sel       = RS_SP;
                            w_two_cycle = 1'b1;
                        end
                    end
                    OP_JUMP: begin
                        funsel = FS_LOAD;
                        r_sel  = RS_PC;
                        arf_i  = r_data;
                        done   = 1'b1;
                    end
                    OP_INIT: begin
                        funsel      = FS_CLR;
                        r_sel       = RS_ALL;
                        w_two_cycle = 1'b1;
                    end
                    default: err = 1'b1;
                endcase
            end
            ST_EXEC2: begin
                case (r_op)
                    OP_FETCH: begin
                        funsel = FS_INC;
                        r_sel  = RS_PC;
                        done   = 1'b1;
                    end
                    OP_PUSH: begin
                        // Write happened at the old SP; now move it down
                        funsel = FS_DEC;
                        r_sel  = RS_SP;
                        done   = 1'b1;
                    end
                    OP_POP: begin
                        // SP was bumped in EXEC1; read the slot it now names
                        out_a_sel = SEL_SP;
                        mem_rd    = 1'b1;
                        done      = 1'b1;
                    end
                    OP_INIT: begin
                        funsel = FS_LOAD;
                        r_sel  = RS_SP;
                        arf_i  = SP_INIT;
                        done   = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign mem_addr = (mem_rd | mem_wr) ? arf_a : 8'h00;

endmodule

// File: tb/tb_arf_sequencer.sv
module tb_arf_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_data;
    logic [7:0] arf_a;
    logic [1:0] funsel;
    logic [3:0] r_sel;
    logic [1:0] out_a_sel;
    logic [1:0] out_b_sel;
    logic [7:0] arf_i;
    logic [7:0] mem_addr;
    logic       mem_rd;
    logic       mem_wr;
    logic       done;
    logic       err;

    always #5 clk = ~clk;

    arf_sequencer #(.SP_INIT(8'hFF), .SP_LIMIT(8'h80)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .arf_a(arf_a), .funsel(funsel),
        .r_sel(r_sel), .out_a_sel(out_a_sel), .out_b_sel(out_b_sel),
        .arf_i(arf_i), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .done(done), .err(err)
    );

    // Stand-in for the address register file (no reset of its own)
    logic [7:0] rf_ar = 8'h00, rf_sp = 8'h00, rf_pcp = 8'h00, rf_pc = 8'h00;

    function automatic logic [7:0] rf_next(input logic [7:0] cur, input logic [1:0] fs,
                                           input logic [7:0] din);
        case (fs)
            2'b00:   return 8'h00;
            2'b01:   return din;
            2'b10:   return cur - 8'h01;
            default: return cur + 8'h01;
        endcase
    endfunction

    always @(posedge clk) begin
        if (r_sel[3]) rf_ar  <= rf_next(rf_ar,  funsel, arf_i);
        if (r_sel[2]) rf_sp  <= rf_next(rf_sp,  funsel, arf_i);
        if (r_sel[1]) rf_pcp <= rf_next(rf_pcp, funsel, arf_i);
        if (r_sel[0]) rf_pc  <= rf_next(rf_pc,  funsel, arf_i);
    end

    always_comb begin
        case (out_a_sel)
            2'b00:   arf_a = rf_ar;
            2'b01:   arf_a = rf_sp;
            2'b10:   arf_a = rf_pcp;
            default: arf_a = rf_pc;
        endcase
    end

    // Expected outcome of one command
    typedef struct {
        logic [2:0] op;
        logic [7:0] d;
        int         busy;     // cycles cmd_ready stays low
        int         ndone;
        int         nerr;
        int         nrd;
        int         nwr;
        logic [7:0] addr;     // address of the strobe, if any
        logic [7:0] ar, sp, pcp, pc;
    } vec_t;

    typedef struct {
        int         busy, ndone, nerr, nrd, nwr, done_cyc, both, bsel_bad, addr_bad;
        logic [7:0] addr;
    } obs_t;

    int nchk = 0;
    int nerrs = 0;

    // High-level model of the register file contents
    logic [7:0] m_ar = 8'h00, m_sp = 8'h00, m_pcp = 8'h00, m_pc = 8'h00;

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act !== exp) begin
            nerrs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] op, input logic [7:0] d, input int busy,
                                input int nd, input int ne, input int nr, input int nw,
                                input logic [7:0] addr, input logic [7:0] ar,
                                input logic [7:0] sp, input logic [7:0] pcp,
                                input logic [7:0] pc);
        vec_t v;
        v.op = op; v.d = d; v.busy = busy; v.ndone = nd; v.nerr = ne; v.nrd = nr;
        v.nwr = nw; v.addr = addr; v.ar = ar; v.sp = sp; v.pcp = pcp; v.pc = pc;
        return v;
    endfunction

    // Apply a command to the model: what the spec says each command does
    task automatic model_exec(input logic [2:0] op, input logic [7:0] d, output vec_t e);
        e = mk(op, d, 1, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        case (op)
            3'd0: ;
            3'd1: begin
                e.busy = 2; e.nrd = 1; e.addr = m_pc;
                m_pcp = m_pc; m_pc = m_pc + 8'h01;
            end
            3'd2: begin
                if (m_sp == 8'h80) begin e.ndone = 0; e.nerr = 1; end
                else begin e.busy = 2; e.nwr = 1; e.addr = m_sp; m_sp = m_sp - 8'h01; end
            end
            3'd3: begin
                if (m_sp == 8'hFF) begin e.ndone = 0; e.nerr = 1; end
                else begin e.busy = 2; m_sp = m_sp + 8'h01; e.nrd = 1; e.addr = m_sp; end
            end
            3'd4: m_pc = d;
            3'd5: begin
                e.busy = 2; m_ar = 8'h00; m_pcp = 8'h00; m_pc = 8'h00; m_sp = 8'hFF;
            end
            default: begin e.ndone = 0; e.nerr = 1; end
        endcase
        e.ar = m_ar; e.sp = m_sp; e.pcp = m_pcp; e.pc = m_pc;
    endtask

    // Drive one command through the handshake and record what came out
    task automatic run_cmd(input logic [2:0] op, input logic [7:0] d, output obs_t o);
        int n;
        o = '{default: 0};
        @(negedge clk);
        cmd_op = op; cmd_data = d; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) begin
            chk("ready_timeout", 0, 1);
            cmd_valid = 1'b0;
            return;
        end
        @(negedge clk);
        // Garbage on the command bus while busy must be ignored
        cmd_valid = 1'b0; cmd_op = 3'($urandom); cmd_data = 8'($urandom);
        n = 0;
        while (!cmd_ready && n < 10) begin
            n++;
            if (done) begin o.ndone++; o.done_cyc = n; end
            if (err) o.nerr++;
            if (done && err) o.both++;
            if (out_b_sel != 2'b00) o.bsel_bad++;
            if (mem_rd) begin o.nrd++; o.addr = mem_addr; end
            if (mem_wr) begin o.nwr++; o.addr = mem_addr; end
            if ((mem_rd || mem_wr) && mem_addr != arf_a) o.addr_bad++;
            if (!(mem_rd || mem_wr) && mem_addr != 8'h00) o.addr_bad++;
            @(negedge clk);
        end
        if (n >= 10) chk("busy_timeout", 0, 1);
        o.busy = n;
    endtask

    task automatic compare(input string tag, input vec_t e, input obs_t o);
        chk({tag, ".busy"},  o.busy,  e.busy);
        chk({tag, ".done"},  o.ndone, e.ndone);
        chk({tag, ".err"},   o.nerr,  e.nerr);
        chk({tag, ".rd"},    o.nrd,   e.nrd);
        chk({tag, ".wr"},    o.nwr,   e.nwr);
        if (e.nrd + e.nwr > 0) chk({tag, ".addr"}, o.addr, e.addr);
        if (e.ndone > 0) chk({tag, ".done_cyc"}, o.done_cyc, e.busy);
        chk({tag, ".done_err"}, o.both, 0);
        chk({tag, ".bsel"},  o.bsel_bad, 0);
        chk({tag, ".maddr"}, o.addr_bad, 0);
        chk({tag, ".AR"},    rf_ar,  e.ar);
        chk({tag, ".SP"},    rf_sp,  e.sp);
        chk({tag, ".PCP"},   rf_pcp, e.pcp);
        chk({tag, ".PC"},    rf_pc,  e.pc);
    endtask

    task automatic model_run(input string tag, input logic [2:0] op, input logic [7:0] d);
        vec_t e;
        obs_t o;
        model_exec(op, d, e);
        run_cmd(op, d, o);
        compare(tag, e, o);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, ".ready"},  cmd_ready, 1);
        chk({tag, ".funsel"}, funsel, 0);
        chk({tag, ".r_sel"},  r_sel, 0);
        chk({tag, ".a_sel"},  out_a_sel, 0);
        chk({tag, ".b_sel"},  out_b_sel, 0);
        chk({tag, ".arf_i"},  arf_i, 0);
        chk({tag, ".strobe"}, {mem_rd, mem_wr, done, err}, 0);
        chk({tag, ".maddr"},  mem_addr, 0);
    endtask

    vec_t tbl[12];

    initial begin
        vec_t e;
        obs_t o;
        int   done_seen;

        tbl[0]  = mk(3'd5, 8'h00, 2, 1, 0, 0, 0, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00); // INIT
        tbl[1]  = mk(3'd4, 8'h3C, 1, 1, 0, 0, 0, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h3C); // JUMP
        tbl[2]  = mk(3'd1, 8'h00, 2, 1, 0, 1, 0, 8'h3C, 8'h00, 8'hFF, 8'h3C, 8'h3D); // FETCH
        tbl[3]  = mk(3'd2, 8'h00, 2, 1, 0, 0, 1, 8'hFF, 8'h00, 8'hFE, 8'h3C, 8'h3D); // PUSH
        tbl[4]  = mk(3'd3, 8'h00, 2, 1, 0, 1, 0, 8'hFF, 8'h00, 8'hFF, 8'h3C, 8'h3D); // POP
        tbl[5]  = mk(3'd3, 8'h00, 1, 0, 1, 0, 0, 8'h00, 8'h00, 8'hFF, 8'h3C, 8'h3D); // POP empty
        tbl[6]  = mk(3'd6, 8'h55, 1, 0, 1, 0, 0, 8'h00, 8'h00, 8'hFF, 8'h3C, 8'h3D); // illegal
        tbl[7]  = mk(3'd7, 8'hAA, 1, 0, 1, 0, 0, 8'h00, 8'h00, 8'hFF, 8'h3C, 8'h3D); // illegal
        tbl[8]  = mk(3'd0, 8'h00, 1, 1, 0, 0, 0, 8'h00, 8'h00, 8'hFF, 8'h3C, 8'h3D); // NOP
        tbl[9]  = mk(3'd4, 8'hFF, 1, 1, 0, 0, 0, 8'h00, 8'h00, 8'hFF, 8'h3C, 8'hFF); // JUMP FF
        tbl[10] = mk(3'd1, 8'h00, 2, 1, 0, 1, 0, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h00); // FETCH wrap
        tbl[11] = mk(3'd5, 8'h00, 2, 1, 0, 0, 0, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00); // INIT

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = 8'h00;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset_held");
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle_outputs("reset_rel");

        // Directed table; the model runs alongside to stay in step
        for (int i = 0; i < 12; i++) begin
            model_exec(tbl[i].op, tbl[i].d, e);
            run_cmd(tbl[i].op, tbl[i].d, o);
            compare($sformatf("tbl%0d", i), tbl[i], o);
        end

        // Stack fill to the limit, then one overflowing push
        model_run("fill_init", 3'd5, 8'h00);
        for (int i = 0; i < 127; i++) model_run($sformatf("push%0d", i), 3'd2, 8'h00);
        chk("fill_sp", rf_sp, 8'h80);
        model_run("push_ovf", 3'd2, 8'h00);
        chk("ovf_sp", rf_sp, 8'h80);
        model_run("pop_after_fill", 3'd3, 8'h00);

        // Reset during EXEC1 of FETCH
        model_run("pre_rst_jump", 3'd4, 8'h10);
        @(negedge clk);
        cmd_op = 3'd1; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("rst_exec1_rd", mem_rd, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_idle", cmd_ready, 1);
        chk("rst_rsel", r_sel, 0);
        done_seen = done;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            done_seen += done;
        end
        chk("rst_no_done", done_seen, 0);
        chk("rst_pc", rf_pc, 8'h10);
        model_run("resync_init", 3'd5, 8'h00);

        // Random commands against the model; JUMP targets kept wide
        for (int i = 0; i < 300; i++) begin
            logic [2:0] op;
            op = 3'($urandom_range(0, 7));
            model_run($sformatf("rnd%0d", i), op, 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", nerrs, nchk);
        $finish;
    end

endmodule
